// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks ALU or LSU/divider result and drives the regfile write port.
// Latency: 1 cycle from accepted transfer to wb_* outputs and instret_o.
// Backpressure: ALU wins by default; a stalled LSU wins after STARVE_LIMIT stalled cycles.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid_i/alu_ready_o + data  single-cycle ALU result channel (valid/ready)
//   lsu_valid_i/lsu_ready_o + data  long-latency LSU/divider result channel (valid/ready)
//   wb_rd_en_o/idx_o/wdata_o        registered register-file write port
//   instret_o                       64-bit retired-instruction count (wraps)
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int IDX_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic             alu_rd_we_i,
    input  logic [IDX_W-1:0] alu_rd_idx_i,
    input  logic [XLEN-1:0]  alu_wdata_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic             lsu_rd_we_i,
    input  logic [IDX_W-1:0] lsu_rd_idx_i,
    input  logic [XLEN-1:0]  lsu_wdata_i,
    output logic             wb_rd_en_o,
    output logic [IDX_W-1:0] wb_rd_idx_o,
    output logic [XLEN-1:0]  wb_rd_wdata_o,
    output logic [63:0]      instret_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_SAT = 4'hF;

    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             wb_rd_en_q, wb_rd_en_d;
    logic [IDX_W-1:0] wb_rd_idx_q, wb_rd_idx_d;
    logic [XLEN-1:0]  wb_rd_wdata_q, wb_rd_wdata_d;
    logic [63:0]      instret_q, instret_d;

    logic starve_hit;
    logic alu_xfer;
    logic lsu_xfer;

    // Readies depend only on valids and the starve counter, never on payload.
    assign starve_hit  = (starve_cnt_q >= STARVE_LIM);
    assign alu_ready_o = ~(lsu_valid_i & starve_hit);
    assign lsu_ready_o = ~alu_valid_i | starve_hit;

    // The ready equations guarantee these two are never high together.
    assign alu_xfer = alu_valid_i & alu_ready_o;
    assign lsu_xfer = lsu_valid_i & lsu_ready_o;

    always_comb begin
        starve_cnt_d  = '0;
        wb_rd_en_d    = 1'b0;
        wb_rd_idx_d   = wb_rd_idx_q;
        wb_rd_wdata_d = wb_rd_wdata_q;
        instret_d     = instret_q;

        // Counter only survives while the LSU is valid and being held off;
        // a grant or an idle LSU both return it to zero.
        if (lsu_valid_i && !lsu_ready_o) begin
            starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? STARVE_SAT : starve_cnt_q + 4'd1;
        end

        if (alu_xfer) begin
            wb_rd_en_d    = alu_rd_we_i && (alu_rd_idx_i != '0);
            wb_rd_idx_d   = alu_rd_idx_i;
            wb_rd_wdata_d = alu_wdata_i;
            instret_d     = instret_q + 64'd1;
        end else if (lsu_xfer) begin
            wb_rd_en_d    = lsu_rd_we_i && (lsu_rd_idx_i != '0);
            wb_rd_idx_d   = lsu_rd_idx_i;
            wb_rd_wdata_d = lsu_wdata_i;
            instret_d     = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q  <= '0;
            wb_rd_en_q    <= 1'b0;
            wb_rd_idx_q   <= '0;
            wb_rd_wdata_q <= '0;
            instret_q     <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            wb_rd_en_q    <= wb_rd_en_d;
            wb_rd_idx_q   <= wb_rd_idx_d;
            wb_rd_wdata_q <= wb_rd_wdata_d;
            instret_q     <= instret_d;
        end
    end

    assign wb_rd_en_o    = wb_rd_en_q;
    assign wb_rd_idx_o   = wb_rd_idx_q;
    assign wb_rd_wdata_o = wb_rd_wdata_q;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a scoreboard queue of expected writebacks.
// Latency checked: expected entry pushed at the accepting cycle, popped one edge later.
// Backpressure checked: readies compared against fixed per-step expectations.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid_i, alu_rd_we_i;
    logic [4:0]  alu_rd_idx_i;
    logic [31:0] alu_wdata_i;
    logic        lsu_valid_i, lsu_rd_we_i;
    logic [4:0]  lsu_rd_idx_i;
    logic [31:0] lsu_wdata_i;
    logic        alu_ready_o, lsu_ready_o;
    logic        wb_rd_en_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_rd_wdata_o;
    logic [63:0] instret_o;

    wb_arbiter #(.XLEN(32), .IDX_W(5), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_rd_we_i   (alu_rd_we_i),
        .alu_rd_idx_i  (alu_rd_idx_i),
        .alu_wdata_i   (alu_wdata_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_we_i   (lsu_rd_we_i),
        .lsu_rd_idx_i  (lsu_rd_idx_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .wb_rd_en_o    (wb_rd_en_o),
        .wb_rd_idx_o   (wb_rd_idx_o),
        .wb_rd_wdata_o (wb_rd_wdata_o),
        .instret_o     (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t     sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_instret = '0;
    logic [4:0]  last_idx    = '0;
    logic [31:0] last_data   = '0;

    localparam int NONE = 0;
    localparam int ALU  = 1;
    localparam int LSU  = 2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic v, input logic we, input logic [4:0] idx, input logic [31:0] d);
        alu_valid_i  = v;
        alu_rd_we_i  = we;
        alu_rd_idx_i = idx;
        alu_wdata_i  = d;
    endtask

    task automatic set_lsu(input logic v, input logic we, input logic [4:0] idx, input logic [31:0] d);
        lsu_valid_i  = v;
        lsu_rd_we_i  = we;
        lsu_rd_idx_i = idx;
        lsu_wdata_i  = d;
    endtask

    // Called just after a negedge with inputs already driven: checks readies,
    // records the expected writeback, then checks the outputs after the edge.
    task automatic step(input string tag, input logic exp_ar, input logic exp_lr, input int src);
        wb_exp_t e;
        #1;
        chk({tag, ".alu_ready"}, {63'd0, alu_ready_o}, {63'd0, exp_ar});
        chk({tag, ".lsu_ready"}, {63'd0, lsu_ready_o}, {63'd0, exp_lr});
        if (src == ALU) begin
            e.en = alu_rd_we_i && (alu_rd_idx_i != 5'd0); e.idx = alu_rd_idx_i; e.data = alu_wdata_i;
            sb.push_back(e);
            exp_instret = exp_instret + 64'd1;
        end else if (src == LSU) begin
            e.en = lsu_rd_we_i && (lsu_rd_idx_i != 5'd0); e.idx = lsu_rd_idx_i; e.data = lsu_wdata_i;
            sb.push_back(e);
            exp_instret = exp_instret + 64'd1;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_idx  = e.idx;
            last_data = e.data;
            chk({tag, ".wb_en"}, {63'd0, wb_rd_en_o}, {63'd0, e.en});
        end else begin
            chk({tag, ".wb_en"}, {63'd0, wb_rd_en_o}, 64'd0);
        end
        chk({tag, ".wb_idx"},   {59'd0, wb_rd_idx_o},   {59'd0, last_idx});
        chk({tag, ".wb_wdata"}, {32'd0, wb_rd_wdata_o}, {32'd0, last_data});
        chk({tag, ".instret"},  instret_o, exp_instret);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_alu(0, 0, 5'd0, 32'd0);
        set_lsu(0, 0, 5'd0, 32'd0);
        #1;
        chk("rst.wb_en",   {63'd0, wb_rd_en_o}, 64'd0);
        chk("rst.instret", instret_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        step("idle0", 1'b1, 1'b1, NONE);

        // Single ALU write, then an idle cycle holding idx/wdata.
        set_alu(1, 1, 5'd5, 32'hDEADBEEF);
        step("alu5", 1'b1, 1'b0, ALU);
        set_alu(0, 0, 5'd0, 32'd0);
        step("idle1", 1'b1, 1'b1, NONE);

        // x0 write from ALU, then LSU store: both retire, no register write.
        set_alu(1, 1, 5'd0, 32'h00001234);
        step("alu_x0", 1'b1, 1'b0, ALU);
        set_alu(0, 0, 5'd0, 32'd0);
        set_lsu(1, 0, 5'd7, 32'h00000055);
        step("lsu_st", 1'b1, 1'b1, LSU);
        set_lsu(0, 0, 5'd0, 32'd0);
        step("idle2", 1'b1, 1'b1, NONE);

        // Both valid continuously: ALU wins four cycles, LSU the fifth, ALU resumes.
        set_lsu(1, 1, 5'd9, 32'hA5A50000);
        for (int i = 0; i < 4; i++) begin
            set_alu(1, 1, 5'(i + 1), 32'h1000 + i);
            step("starve_alu", 1'b1, 1'b0, ALU);
        end
        set_alu(1, 1, 5'd20, 32'h2000);
        step("starve_lsu", 1'b0, 1'b1, LSU);
        set_lsu(1, 1, 5'd10, 32'hA5A50001);
        step("resume_alu", 1'b1, 1'b0, ALU);
        set_alu(0, 0, 5'd0, 32'd0);
        set_lsu(0, 0, 5'd0, 32'd0);
        step("idle3", 1'b1, 1'b1, NONE);

        // Counter wrap at 2^64.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        set_alu(1, 1, 5'd3, 32'hCAFEF00D);
        step("wrap", 1'b1, 1'b0, ALU);
        set_alu(0, 0, 5'd0, 32'd0);
        step("idle4", 1'b1, 1'b1, NONE);

        // Stall LSU three cycles (counter=3), then reset mid-stall.
        set_lsu(1, 1, 5'd11, 32'h0BADC0DE);
        for (int i = 0; i < 3; i++) begin
            set_alu(1, 1, 5'(i + 12), 32'h3000 + i);
            step("pre_rst", 1'b1, 1'b0, ALU);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.wb_en",    {63'd0, wb_rd_en_o}, 64'd0);
        chk("midrst.wb_idx",   {59'd0, wb_rd_idx_o}, 64'd0);
        chk("midrst.wb_wdata", {32'd0, wb_rd_wdata_o}, 64'd0);
        chk("midrst.instret",  instret_o, 64'd0);
        chk("midrst.lsu_ready", {63'd0, lsu_ready_o}, 64'd0);
        sb.delete();
        exp_instret = '0;
        last_idx    = '0;
        last_data   = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Counter restarts from zero: four more ALU grants before LSU wins.
        for (int i = 0; i < 4; i++) begin
            set_alu(1, 1, 5'(i + 16), 32'h4000 + i);
            step("post_rst_alu", 1'b1, 1'b0, ALU);
        end
        set_alu(1, 1, 5'd21, 32'h5000);
        step("post_rst_lsu", 1'b0, 1'b1, LSU);
        set_alu(0, 0, 5'd0, 32'd0);
        set_lsu(0, 0, 5'd0, 32'd0);
        step("idle5", 1'b1, 1'b1, NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
